// File: rtl/ucie_sched_pkg.sv
// ucie_sched_pkg: shared link-state encoding, default sizing and round-robin helper
package ucie_sched_pkg;

    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        INIT   = 2'd1,
        ACTIVE = 2'd2
    } link_state_e;

    localparam int NUM_VC_DEF   = 4;
    localparam int MAX_CRD_DEF  = 15;
    localparam int INIT_CRD_DEF = 8;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/ucie_vc_credit_ctr.sv
// ucie_vc_credit_ctr: per-VC saturating credit counter with load, clear and zero flag
module ucie_vc_credit_ctr #(
    parameter int MAX_CRD = 15,
    parameter int CW      = $clog2(MAX_CRD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    assign zero = (cnt == '0);

    // clear beats load beats arithmetic; a simultaneous inc and dec cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !inc) cnt <= cnt - 1'b1;
        else if (inc && !dec && cnt != CW'(MAX_CRD)) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ucie_tx_vc_scheduler.sv
// ucie_tx_vc_scheduler: credit-gated round-robin VC flit scheduler; optional UCIE_SCHED_STALL_WDOG_EN adds per-VC stall watchdog
module ucie_tx_vc_scheduler
    import ucie_sched_pkg::*;
#(
    parameter int NUM_VC   = NUM_VC_DEF,
    parameter int MAX_CRD  = MAX_CRD_DEF,
    parameter int INIT_CRD = INIT_CRD_DEF,
    parameter int VCW      = $clog2(NUM_VC),
    parameter int CW       = $clog2(MAX_CRD + 1)
`ifdef UCIE_SCHED_STALL_WDOG_EN
   ,parameter int WDOG_CYC = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_up,
    input  logic [NUM_VC-1:0]    req_valid,
    output logic [NUM_VC-1:0]    req_ready,
    output logic                 tx_valid,
    output logic [VCW-1:0]       tx_vc,
    input  logic                 tx_ready,
    input  logic [NUM_VC-1:0]    crd_ret,
    output logic [NUM_VC*CW-1:0] crd_avail,
    output logic [1:0]           link_state
`ifdef UCIE_SCHED_STALL_WDOG_EN
   ,output logic [NUM_VC-1:0]    stall_to
`endif
);

    link_state_e       state, state_nxt;
    logic [NUM_VC-1:0] zero, elig;
    logic [VCW-1:0]    rr_ptr, gidx, idx;
    logic              found, slot_free, active;

    assign active     = (state == ACTIVE);
    assign slot_free  = !tx_valid || tx_ready;
    assign elig       = (active && slot_free) ? (req_valid & ~zero) : '0;
    assign link_state = state;

    // link state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DOWN;
        else state <= state_nxt;
    end

    // losing the link overrides everything; INIT is a single load cycle
    always_comb begin
        state_nxt = !link_up ? DOWN : (state == DOWN ? INIT : ACTIVE);
    end

    // first eligible VC at or after the round-robin pointer, granted combinationally
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            idx = VCW'((int'(rr_ptr) + k) % NUM_VC);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        req_ready = found ? (NUM_VC'(1) << gidx) : '0;
    end

    // flit slot and pointer; a link drop discards whatever occupies the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_vc    <= '0;
            rr_ptr   <= '0;
        end else begin
            tx_valid <= link_up && (found || (tx_valid && !tx_ready));
            if (found) begin
                tx_vc  <= gidx;
                rr_ptr <= VCW'(rr_next(int'(gidx), NUM_VC));
            end
        end
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_crd
        ucie_vc_credit_ctr #(
            .MAX_CRD (MAX_CRD),
            .CW      (CW)
        ) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .clear    (!link_up),
            .load     (state == INIT),
            .load_val (CW'(INIT_CRD)),
            .dec      (req_ready[i]),
            .inc      (crd_ret[i] && active),
            .cnt      (crd_avail[i*CW +: CW]),
            .zero     (zero[i])
        );
    end

`ifdef UCIE_SCHED_STALL_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);

    for (genvar i = 0; i < NUM_VC; i++) begin : g_wdog
        logic [WW-1:0] cnt;
        logic          starve;

        assign starve = active && req_valid[i] && zero[i];

        // count consecutive starved cycles; the flag latches as the count reaches the limit
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt         <= '0;
                stall_to[i] <= 1'b0;
            end else if (!link_up) begin
                cnt         <= '0;
                stall_to[i] <= 1'b0;
            end else begin
                cnt <= starve ? ((cnt == WW'(WDOG_CYC)) ? cnt : cnt + 1'b1) : '0;
                if (starve && cnt == WW'(WDOG_CYC - 1)) stall_to[i] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucie_tx_vc_scheduler.sv
// tb_ucie_tx_vc_scheduler: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_ucie_tx_vc_scheduler;

    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int MAXC  = 15;
    localparam int INITC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          link_up = 1'b0;
    logic          tx_ready = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  crd_ret = '0;
    logic [N-1:0]  req_ready;
    logic          tx_valid;
    logic [1:0]    tx_vc;
    logic [N*CW-1:0] crd_avail;
    logic [1:0]    link_state;
`ifdef UCIE_SCHED_STALL_WDOG_EN
    logic [N-1:0]  stall_to;
`endif

    int errors = 0;
    int checks = 0;

    // reference model: 0=DOWN 1=INIT 2=ACTIVE, credits as plain integers
    int m_state, m_ptr, m_txvc, m_g;
    bit m_txv;
    int m_crd [N];

    ucie_tx_vc_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .link_up    (link_up),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .tx_valid   (tx_valid),
        .tx_vc      (tx_vc),
        .tx_ready   (tx_ready),
        .crd_ret    (crd_ret),
        .crd_avail  (crd_avail),
        .link_state (link_state)
`ifdef UCIE_SCHED_STALL_WDOG_EN
       ,.stall_to   (stall_to)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_rr();
        logic [N-1:0] r = '0;
        if (m_g >= 0) r[m_g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*CW-1:0] exp_crd();
        logic [N*CW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_crd[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_txv   = 0;
        m_txvc  = 0;
        m_g     = -1;
        for (int i = 0; i < N; i++) m_crd[i] = 0;
    endtask

    // apply inputs, settle, and work out which VC the rules say wins this cycle
    task automatic drive(input logic l, input logic [N-1:0] rq, input logic rdy, input logic [N-1:0] rt);
        link_up   = l;
        req_valid = rq;
        tx_ready  = rdy;
        crd_ret   = rt;
        #1;
        m_g = -1;
        if (m_state == 2 && (!m_txv || tx_ready)) begin
            for (int k = 0; k < N; k++) begin
                int v;
                v = (m_ptr + k) % N;
                if (m_g < 0 && req_valid[v] && m_crd[v] > 0) m_g = v;
            end
        end
    endtask

    // advance one clock and apply the state-update rules to the model
    task automatic clock();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!link_up) m_crd[i] = 0;
            else if (m_state == 1) m_crd[i] = INITC;
            else if (m_state == 2) begin
                m_crd[i] = m_crd[i] + (crd_ret[i] ? 1 : 0) - (m_g == i ? 1 : 0);
                if (m_crd[i] > MAXC) m_crd[i] = MAXC;
            end
        end
        m_txv = link_up && (m_g >= 0 || (m_txv && !tx_ready));
        if (m_g >= 0) begin
            m_txvc = m_g;
            m_ptr  = (m_g + 1) % N;
        end
        m_state = !link_up ? 0 : (m_state == 0 ? 1 : 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 4'hF, 1'b1, 4'h0);
        checks++; if (link_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", link_state); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_vc !== 2'd0) begin errors++; $display("FAIL reset_tx_vc: got %0d expected 0", tx_vc); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        checks++; if (crd_avail !== 16'h0) begin errors++; $display("FAIL reset_crd: got %h expected 0", crd_avail); end
    endtask

    task automatic test_bringup();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'hF, 1'b1, 4'h0);
            checks++; if (link_state !== 2'd0 || req_ready !== 4'h0) begin errors++; $display("FAIL bringup_down: state %0d ready %h expected 0/0", link_state, req_ready); end
            clock();
        end
        drive(1'b1, 4'hF, 1'b1, 4'h0);
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bringup_down_grant: got %h expected 0", req_ready); end
        clock();
        drive(1'b1, 4'hF, 1'b1, 4'h0);
        checks++; if (link_state !== 2'd1) begin errors++; $display("FAIL bringup_init: got %0d expected 1", link_state); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bringup_init_grant: got %h expected 0", req_ready); end
        clock();
        drive(1'b1, 4'hF, 1'b1, 4'h0);
        checks++; if (link_state !== 2'd2) begin errors++; $display("FAIL bringup_active: got %0d expected 2", link_state); end
        checks++; if (crd_avail !== 16'h8888) begin errors++; $display("FAIL bringup_crd: got %h expected 8888", crd_avail); end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] want;
            logic [1:0]   prev;
            want = '0;
            want[k % N] = 1'b1;
            prev = 2'((k + N - 1) % N);
            drive(1'b1, 4'hF, 1'b1, 4'h0);
            checks++; if (req_ready !== want) begin errors++; $display("FAIL rr_grant%0d: got %h expected %h", k, req_ready, want); end
            checks++; if (req_ready !== exp_rr()) begin errors++; $display("FAIL rr_model%0d: got %h expected %h", k, req_ready, exp_rr()); end
            if (k > 0) begin
                checks++; if (tx_valid !== 1'b1 || tx_vc !== prev) begin errors++; $display("FAIL rr_txvc%0d: got %b/%0d expected 1/%0d", k, tx_valid, tx_vc, prev); end
            end
            clock();
        end
        drive(1'b1, 4'h0, 1'b1, 4'h0);
        checks++; if (crd_avail !== 16'h6666) begin errors++; $display("FAIL rr_crd: got %h expected 6666", crd_avail); end
        clock();
    endtask

    task automatic test_link_drop();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'hF, 1'b1, 4'h0);
            clock();
        end
        drive(1'b0, 4'hF, 1'b1, 4'h0);
        clock();
        drive(1'b1, 4'h0, 1'b1, 4'h0);
        checks++; if (link_state !== 2'd0) begin errors++; $display("FAIL drop_state: got %0d expected 0", link_state); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (crd_avail !== 16'h0) begin errors++; $display("FAIL drop_crd: got %h expected 0", crd_avail); end
        clock();
        drive(1'b1, 4'h0, 1'b1, 4'hF);
        clock();
        drive(1'b1, 4'h0, 1'b1, 4'h0);
        checks++; if (link_state !== 2'd2 || crd_avail !== 16'h8888) begin errors++; $display("FAIL drop_reload: got %0d/%h expected 2/8888", link_state, crd_avail); end
    endtask

    task automatic test_exhaustion();
        int grants = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 4'b0100, 1'b1, 4'h0);
            checks++; if (req_ready !== exp_rr()) begin errors++; $display("FAIL exh_model%0d: got %h expected %h", c, req_ready, exp_rr()); end
            if (req_ready[2]) grants++;
            clock();
        end
        checks++; if (grants != INITC) begin errors++; $display("FAIL exh_count: got %0d expected %0d", grants, INITC); end
        checks++; if (crd_avail[11:8] !== 4'd0) begin errors++; $display("FAIL exh_crd: got %0d expected 0", crd_avail[11:8]); end
        drive(1'b1, 4'b0000, 1'b1, 4'b0100);
        clock();
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 4'b0100, 1'b1, 4'h0);
            if (req_ready[2]) grants++;
            clock();
        end
        checks++; if (grants != 1) begin errors++; $display("FAIL exh_return: got %0d expected 1", grants); end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'h0, 1'b1, 4'b0010);
            clock();
        end
        drive(1'b1, 4'h0, 1'b1, 4'b0010);
        checks++; if (crd_avail[7:4] !== 4'd15) begin errors++; $display("FAIL sat_fill: got %0d expected 15", crd_avail[7:4]); end
        clock();
        drive(1'b1, 4'h0, 1'b1, 4'h0);
        checks++; if (crd_avail[7:4] !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", crd_avail[7:4]); end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 4'b0010, 1'b1, 4'h0);
            clock();
        end
        drive(1'b1, 4'b0010, 1'b1, 4'b0010);
        checks++; if (crd_avail[7:4] !== 4'd5) begin errors++; $display("FAIL sat_drain: got %0d expected 5", crd_avail[7:4]); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sat_both_grant: got %h expected 2", req_ready); end
        clock();
        drive(1'b1, 4'h0, 1'b1, 4'h0);
        checks++; if (crd_avail[7:4] !== 4'd5) begin errors++; $display("FAIL sat_both: got %0d expected 5", crd_avail[7:4]); end
        checks++; if (crd_avail !== exp_crd()) begin errors++; $display("FAIL sat_model: got %h expected %h", crd_avail, exp_crd()); end
        clock();
    endtask

    task automatic test_backpressure();
        logic [1:0] held;
        drive(1'b1, 4'b0011, 1'b1, 4'h0);
        checks++; if (req_ready === 4'h0 || req_ready !== exp_rr()) begin errors++; $display("FAIL bp_first: got %h expected %h", req_ready, exp_rr()); end
        held = 2'(m_g);
        clock();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'b0011, 1'b0, 4'h0);
            checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_stall%0d: got %h expected 0", c, req_ready); end
            checks++; if (tx_valid !== 1'b1 || tx_vc !== held) begin errors++; $display("FAIL bp_hold%0d: got %b/%0d expected 1/%0d", c, tx_valid, tx_vc, held); end
            clock();
        end
        drive(1'b1, 4'b0011, 1'b1, 4'h0);
        checks++; if (req_ready === 4'h0 || req_ready !== exp_rr()) begin errors++; $display("FAIL bp_release: got %h expected %h", req_ready, exp_rr()); end
        clock();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] rt;
            for (int i = 0; i < N; i++) rt[i] = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 39) != 0), N'($urandom), ($urandom_range(0, 3) != 0), rt);
            checks++; if (req_ready !== exp_rr()) begin errors++; $display("FAIL rnd_grant%0d: got %h expected %h", c, req_ready, exp_rr()); end
            checks++; if (tx_valid !== m_txv) begin errors++; $display("FAIL rnd_txv%0d: got %b expected %b", c, tx_valid, m_txv); end
            if (m_txv) begin
                checks++; if (tx_vc !== 2'(m_txvc)) begin errors++; $display("FAIL rnd_txvc%0d: got %0d expected %0d", c, tx_vc, m_txvc); end
            end
            checks++; if (crd_avail !== exp_crd()) begin errors++; $display("FAIL rnd_crd%0d: got %h expected %h", c, crd_avail, exp_crd()); end
            checks++; if (link_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state%0d: got %0d expected %0d", c, link_state, m_state); end
            clock();
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 4'hF, 1'b1, 4'hF);
            clock();
        end
        drive(1'b1, 4'hF, 1'b1, 4'h0);
        #1 rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || link_state !== 2'd0) begin errors++; $display("FAIL arst_ctrl: got %b/%0d expected 0/0", tx_valid, link_state); end
        checks++; if (crd_avail !== 16'h0 || req_ready !== 4'h0) begin errors++; $display("FAIL arst_crd: got %h/%h expected 0/0", crd_avail, req_ready); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_bringup();
        test_round_robin();
        test_link_drop();
        test_exhaustion();
        test_saturation();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
